// File: rtl/seq_tag_allocator_if.sv
// Handshake bundle between the instruction front end and the sequence tag allocator.
// The front end drives requests via the master modport; the allocator answers via the slave modport.
interface seq_tag_allocator_if #(
    parameter int TAG_W = 8
);
    logic             alloc_req;
    logic             alloc_ok;
    logic [TAG_W-1:0] alloc_tag;
    logic             commit;
    logic [TAG_W-1:0] commit_tag;
    logic             flush;
    logic [TAG_W-1:0] flush_tag;
    logic [TAG_W-1:0] count;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output alloc_req,
        output commit,
        output flush,
        output flush_tag,
        input  alloc_ok,
        input  alloc_tag,
        input  commit_tag,
        input  count,
        input  full,
        input  empty,
        input  err
    );

    modport slave (
        input  alloc_req,
        input  commit,
        input  flush,
        input  flush_tag,
        output alloc_ok,
        output alloc_tag,
        output commit_tag,
        output count,
        output full,
        output empty,
        output err
    );
endinterface

// File: rtl/seq_tag_allocator.sv
// Wrap-around sequence tag allocator tracking the in-flight window head..tail.
// Define SEQ_TAG_ALLOC_CHECK_EN to build the sticky illegal-operation flag on err.
module seq_tag_allocator #(
    parameter int TAG_W  = 8,
    parameter int WINDOW = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_tag_allocator_if.slave   bus
);

    localparam logic [TAG_W-1:0] WINDOW_TAG = TAG_W'(WINDOW);
    localparam logic [TAG_W-1:0] ZERO_TAG   = {TAG_W{1'b0}};

    function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
        return t + TAG_W'(1);
    endfunction

    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W-1:0] head_nxt_s;
    logic [TAG_W-1:0] tail_nxt_s;
    logic [TAG_W-1:0] count_s;
    logic [TAG_W-1:0] flush_off_s;
    logic             full_s;
    logic             empty_s;
    logic             alloc_fire_s;
    logic             commit_fire_s;
    logic             flush_valid_s;

    // Window occupancy and acceptance of each operation against the pre-edge state
    always_comb begin
        count_s       = tail_r - head_r;
        full_s        = (count_s == WINDOW_TAG);
        empty_s       = (count_s == ZERO_TAG);
        flush_off_s   = bus.flush_tag - head_r;
        flush_valid_s = bus.flush && (flush_off_s < count_s);
        alloc_fire_s  = bus.alloc_req && !full_s && !bus.flush;
        commit_fire_s = bus.commit && !empty_s;
    end

    // Next head/tail; a flush always suppresses alloc, even when the flush itself is rejected
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        if (commit_fire_s) begin
            head_nxt_s = tag_inc(head_r);
        end else begin
            head_nxt_s = head_r;
        end
        if (flush_valid_s) begin
            tail_nxt_s = tag_inc(bus.flush_tag);
        end else if (alloc_fire_s) begin
            tail_nxt_s = tag_inc(tail_r);
        end else begin
            tail_nxt_s = tail_r;
        end
    end

    // Window pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r <= ZERO_TAG;
            tail_r <= ZERO_TAG;
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
        end
    end

`ifdef SEQ_TAG_ALLOC_CHECK_EN
    logic err_r;
    logic illegal_s;

    // Any operation the window cannot honour
    always_comb begin
        illegal_s = (bus.commit && empty_s)
                  | (bus.flush && !flush_valid_s)
                  | (bus.alloc_req && full_s);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | illegal_s;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.alloc_ok   = !full_s;
    assign bus.alloc_tag  = tail_r;
    assign bus.commit_tag = head_r;
    assign bus.count      = count_s;
    assign bus.full       = full_s;
    assign bus.empty      = empty_s;

endmodule

// File: tb/tb_seq_tag_allocator.sv
// Directed bench for seq_tag_allocator: a vector table plus hand-written
// sequences for fill, wrap, flush, flush-with-commit and mid-run reset.
module tb_seq_tag_allocator;

`ifdef SEQ_TAG_ALLOC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk;
    logic reset;

    seq_tag_allocator_if #(.TAG_W(8)) bus ();

    seq_tag_allocator #(.TAG_W(8), .WINDOW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       areq;
        logic       cmt;
        logic       fl;
        logic [7:0] ftag;
        logic [7:0] e_atag;
        logic [7:0] e_ctag;
        logic [7:0] e_cnt;
        logic       e_full;
        logic       e_empty;
        logic       e_ok;
        logic       e_err;
    } vec_t;

    vec_t vecs [11];
    int   n_vec;
    int   n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic c, input logic f,
                        input logic [7:0] ft);
        reset         = r;
        bus.alloc_req = a;
        bus.commit    = c;
        bus.flush     = f;
        bus.flush_tag = ft;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.alloc_req = 1'b0;
        bus.commit    = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_tag = 8'd0;
    endtask

    // Bring the window to head=h, tail=t using only legal operations
    task automatic set_window(input int h, input int t);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        if (h != 0) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            repeat (h - 1) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        repeat ((t - h + 256) % 256) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic chk_state(input string nm, input int atag, input int ctag, input int cnt,
                             input logic e_err);
        chk({nm, ".alloc_tag"},  {24'd0, bus.alloc_tag},  atag);
        chk({nm, ".commit_tag"}, {24'd0, bus.commit_tag}, ctag);
        chk({nm, ".count"},      {24'd0, bus.count},      cnt);
        chk({nm, ".empty"},      {31'd0, bus.empty},      {31'd0, (cnt == 0)});
        chk({nm, ".full"},       {31'd0, bus.full},       {31'd0, (cnt == 64)});
        chk({nm, ".alloc_ok"},   {31'd0, bus.alloc_ok},   {31'd0, (cnt != 64)});
        chk({nm, ".err"},        {31'd0, bus.err},        {31'd0, e_err});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.alloc_req = 1'b0;
        bus.commit    = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_tag = 8'd0;

        //          rst   areq  cmt   fl    ftag   atag   ctag   cnt   full  empty ok    err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 8'd0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd2, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1, 1'b1, CHK};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 8'd3, 8'd1, 1'b0, 1'b0, 1'b1, CHK};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd4, 8'd3, 8'd1, 1'b0, 1'b0, 1'b1, CHK};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].areq, vecs[i].cmt, vecs[i].fl, vecs[i].ftag);
            chk($sformatf("vec%0d.alloc_tag", i),  {24'd0, bus.alloc_tag},  {24'd0, vecs[i].e_atag});
            chk($sformatf("vec%0d.commit_tag", i), {24'd0, bus.commit_tag}, {24'd0, vecs[i].e_ctag});
            chk($sformatf("vec%0d.count", i),      {24'd0, bus.count},      {24'd0, vecs[i].e_cnt});
            chk($sformatf("vec%0d.full", i),       {31'd0, bus.full},       {31'd0, vecs[i].e_full});
            chk($sformatf("vec%0d.empty", i),      {31'd0, bus.empty},      {31'd0, vecs[i].e_empty});
            chk($sformatf("vec%0d.alloc_ok", i),   {31'd0, bus.alloc_ok},   {31'd0, vecs[i].e_ok});
            chk($sformatf("vec%0d.err", i),        {31'd0, bus.err},        {31'd0, vecs[i].e_err});
        end

        // Fill the window: 64 grants, then a refused 65th request
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("fill%0d.alloc_tag", i), {24'd0, bus.alloc_tag}, i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        end
        chk_state("full64", 64, 0, 64, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk_state("full65", 64, 0, 64, CHK);

        // Alloc and commit together for 300 cycles across the 255->0 wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        begin
            int exp_tail;
            exp_tail = 1;
            for (int k = 0; k < 300; k++) begin
                step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
                exp_tail = (exp_tail + 1) % 256;
                chk($sformatf("wrap%0d.alloc_tag", k),  {24'd0, bus.alloc_tag},  exp_tail);
                chk($sformatf("wrap%0d.commit_tag", k), {24'd0, bus.commit_tag}, (exp_tail + 255) % 256);
                chk($sformatf("wrap%0d.count", k),      {24'd0, bus.count},      1);
            end
        end

        // Valid flush across the wrap suppresses the concurrent alloc
        set_window(250, 10);
        chk_state("flush_pre", 10, 250, 16, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
        chk_state("flush_ok", 3, 250, 9, 1'b0);

        // Out-of-window flush changes nothing
        set_window(250, 10);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd20);
        chk_state("flush_bad", 10, 250, 16, CHK);

        // Flush to head together with commit empties the window
        set_window(5, 9);
        chk_state("fc_pre", 9, 5, 4, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
        chk_state("flush_commit", 6, 6, 0, 1'b0);

        // Reset mid-run overrides concurrent requests and clears err
        set_window(100, 140);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd99);
        chk_state("mid_pre", 140, 100, 40, CHK);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'd120);
        chk_state("mid_reset", 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
